// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: default sizes, reset PC,
// FSM encoding and the queue pointer width helper.
package ifetch_queue_pkg;

    localparam int          IFQ_DEPTH    = 32'd4;
    localparam int          IFQ_ADDR_W   = 32'd32;
    localparam int          IFQ_DATA_W   = 32'd32;
    localparam int unsigned IFQ_RESET_PC = 32'd0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ifq_state_e;

    // Queue pointer width; a 1-entry floor keeps degenerate sizes elaborating.
    function automatic int ifq_ptr_w(input int depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

endpackage

// File: rtl/ifetch_queue_chk.sv
// Protocol and credit invariants for ifetch_queue, kept apart from the datapath.
module ifetch_queue_chk #(
    parameter int DEPTH = 32'd4,
    parameter int CNT_W = 32'd3
) (
    input logic             clk,
    input logic             rst,
    input logic             rsp_valid,
    input logic [CNT_W-1:0] outstanding,
    input logic [CNT_W-1:0] discard,
    input logic             fifo_full,
    input logic             fifo_push,
    input logic             fifo_pop
);
    a_rsp_has_credit: assert property (@(posedge clk) disable iff (!rst)
        rsp_valid |-> (outstanding != CNT_W'(0)));

    a_outstanding_cap: assert property (@(posedge clk) disable iff (!rst)
        outstanding <= CNT_W'(DEPTH));

    a_discard_bound: assert property (@(posedge clk) disable iff (!rst)
        discard <= outstanding);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        (fifo_push && fifo_full) |-> fifo_pop);

endmodule

// File: rtl/ifetch_queue_fifo.sv
// ifq_fifo: DEPTH-entry synchronous FIFO of {pc, instr} with flush, full,
// empty and occupancy count. The head reads as zero while the FIFO is empty.
module ifq_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int WIDTH = IFQ_ADDR_W + IFQ_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head,
    output logic                          full,
    output logic                          empty,
    output logic [ifq_ptr_w(DEPTH):0]     count
);
    localparam int PTR_W = ifq_ptr_w(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Handshake qualification and head presentation
    always_comb begin
        empty     = (count_r == (PTR_W+1)'(0));
        full      = (count_r == (PTR_W+1)'(DEPTH));
        count     = count_r;
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        if (empty) begin
            head = {WIDTH{1'b0}};
        end else begin
            head = mem_r[rd_ptr_r];
        end
    end

    // Entry storage; a push on a full FIFO overwrites the slot popped this cycle
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; flush wins over any push/pop in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= (PTR_W+1)'(0);
        end else if (flush) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= (PTR_W+1)'(0);
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            count_r <= count_r + (PTR_W+1)'(do_push_s) - (PTR_W+1)'(do_pop_s);
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch PC owner, credit-limited imem requester and in-order
// instruction buffer for decode. Optional counters: define IFETCH_STATS_EN.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int                DEPTH    = IFQ_DEPTH,
    parameter int                ADDR_W   = IFQ_ADDR_W,
    parameter int                DATA_W   = IFQ_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFQ_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [DATA_W-1:0] dec_instr,
    output logic [ADDR_W-1:0] dec_pc
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_discarded,
    output logic [31:0]       stat_stall
`endif
);
    localparam int PTR_W = ifq_ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ifq_state_e               state_r;
    ifq_state_e               state_next_s;
    logic [ADDR_W-1:0]        fetch_pc_r;
    logic [ADDR_W-1:0]        resp_pc_r;
    logic [CNT_W-1:0]         outstanding_r;
    logic [CNT_W-1:0]         discard_r;
    logic [CNT_W-1:0]         outstanding_next_s;
    logic [CNT_W-1:0]         fifo_count_s;
    logic [CNT_W:0]           credit_s;
    logic                     fifo_empty_s;
    logic                     fifo_full_s;
    logic                     req_valid_s;
    logic                     req_fire_s;
    logic                     rsp_ok_s;
    logic                     rsp_keep_s;
    logic                     rsp_drop_s;
    logic                     pop_s;
    logic [ADDR_W+DATA_W-1:0] fifo_head_s;

    // FSM next state: fetch runs while enable is held
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) state_next_s = ST_RUN;
                else        state_next_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!enable) state_next_s = ST_IDLE;
                else         state_next_s = ST_RUN;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Credit check, handshakes and response routing; redirect-cycle responses are stale
    always_comb begin
        credit_s           = {1'b0, fifo_count_s} + {1'b0, outstanding_r};
        req_valid_s        = (state_r == ST_RUN) && (credit_s < (CNT_W+1)'(DEPTH));
        req_fire_s         = req_valid_s && imem_req_ready;
        rsp_ok_s           = imem_rsp_valid && (outstanding_r != CNT_W'(0));
        rsp_keep_s         = rsp_ok_s && (discard_r == CNT_W'(0)) && !redirect_valid;
        rsp_drop_s         = rsp_ok_s && !rsp_keep_s;
        pop_s              = !fifo_empty_s && dec_ready;
        outstanding_next_s = outstanding_r + CNT_W'(req_fire_s) - CNT_W'(rsp_ok_s);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= ST_IDLE;
        else      state_r <= state_next_s;
    end

    // PC, in-flight and discard tracking; redirect drops everything still in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= CNT_W'(0);
            discard_r     <= CNT_W'(0);
        end else begin
            outstanding_r <= outstanding_next_s;
            if (redirect_valid) begin
                fetch_pc_r <= redirect_pc;
                resp_pc_r  <= redirect_pc;
                discard_r  <= outstanding_next_s;
            end else begin
                if (req_fire_s) fetch_pc_r <= fetch_pc_r + ADDR_W'(1);
                if (rsp_keep_s) resp_pc_r  <= resp_pc_r + ADDR_W'(1);
                if (rsp_ok_s && (discard_r != CNT_W'(0))) discard_r <= discard_r - CNT_W'(1);
            end
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_keep_s),
        .push_data ({resp_pc_r, imem_rsp_data}),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    ifetch_queue_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .rsp_valid   (imem_rsp_valid),
        .outstanding (outstanding_r),
        .discard     (discard_r),
        .fifo_full   (fifo_full_s),
        .fifo_push   (rsp_keep_s),
        .fifo_pop    (pop_s)
    );

    assign imem_req_valid      = req_valid_s;
    assign imem_req_addr       = fetch_pc_r;
    assign dec_valid           = !fifo_empty_s;
    assign {dec_pc, dec_instr} = fifo_head_s;

`ifdef IFETCH_STATS_EN
    // Free-running wrap-around statistics
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_fetched   <= 32'd0;
            stat_discarded <= 32'd0;
            stat_stall     <= 32'd0;
        end else begin
            stat_fetched   <= stat_fetched + 32'(pop_s);
            stat_discarded <= stat_discarded + 32'(rsp_drop_s);
            stat_stall     <= stat_stall + 32'((state_r == ST_RUN) && !req_valid_s);
        end
    end
`else
    logic unused_drop_s;
    assign unused_drop_s = rsp_drop_s;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed vector table, hand-written
// redirect/wrap/reset sequences and a randomized run against an epoch-based model.
`timescale 1ns/1ps
module tb_ifetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
`ifdef IFETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_discarded;
    logic [31:0] stat_stall;
`endif

    ifetch_queue #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc)
`ifdef IFETCH_STATS_EN
        , .stat_fetched(stat_fetched), .stat_discarded(stat_discarded),
        .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; int ep; } memreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct {
        bit en; bit rdy; bit drdy;
        bit rv; logic [31:0] addr; bit dv; logic [31:0] dpc;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // reference model: in-flight memory requests and instructions owed to decode
    memreq_t     mem_q[$];
    ent_t        m_fifo[$];
    bit          m_run;
    logic [31:0] m_pc;
    int          epoch = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          lat = 1;
    int unsigned m_pops, m_drop, m_stall;

    // per-cycle stimulus
    bit          s_en, s_rdy, s_drdy, s_redir;
    logic [31:0] s_rpc;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge: compare outputs with the model, drive inputs, advance one cycle.
    task automatic cycle();
        bit      exp_rv, fire, pop, rsp;
        memreq_t r;
        int      due;
        exp_rv = m_run && ((m_fifo.size() + mem_q.size()) < DEPTH);
        check("req_valid", imem_req_valid, exp_rv);
        check("req_addr", imem_req_addr, m_pc);
        check("dec_valid", dec_valid, m_fifo.size() != 0);
        if (dec_valid && m_fifo.size() != 0) begin
            check("dec_pc", dec_pc, m_fifo[0].pc);
            check("dec_instr", dec_instr, m_fifo[0].data);
        end

        rsp = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        enable         = s_en;
        imem_req_ready = s_rdy;
        dec_ready      = s_drdy;
        redirect_valid = s_redir;
        redirect_pc    = s_rpc;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_fn(mem_q[0].addr) : $urandom;

        fire = exp_rv && s_rdy;
        pop  = (m_fifo.size() != 0) && s_drdy;
        if (pop) begin
            void'(m_fifo.pop_front());
            m_pops++;
        end
        if (rsp) begin
            r = mem_q.pop_front();
            if (r.ep != epoch || s_redir) m_drop++;
            else m_fifo.push_back('{r.addr, mem_fn(r.addr)});
        end
        if (fire) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{m_pc, due, epoch});
            m_pc = m_pc + 32'd1;
        end
        if (s_redir) begin
            m_fifo.delete();
            epoch++;
            m_pc = s_rpc;
        end
        if (m_run && !exp_rv) m_stall++;
        m_run = s_en;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        enable = 1'b0; imem_req_ready = 1'b0; dec_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        s_en = 1'b0; s_rdy = 1'b0; s_drdy = 1'b0; s_redir = 1'b0; s_rpc = 32'd0;
        mem_q.delete(); m_fifo.delete();
        m_run = 1'b0; m_pc = RESET_PC; epoch++; last_due = 0;
        m_pops = 0; m_drop = 0; m_stall = 0;
        #1;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_dec_valid", dec_valid, 1'b0);
        check("rst_dec_instr", dec_instr, 32'd0);
        check("rst_dec_pc", dec_pc, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_first_pc(input string name, input logic [31:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (dec_valid) begin
                seen = 1'b1;
                check(name, dec_pc, exp);
            end else begin
                cycle();
            end
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL %s: no dec_valid within 40 cycles, expected pc 0x%0h", name, exp);
        end
    endtask

    vec_t vec[16];

    initial begin
        // stall then drain, latency 1: four requests fill the queue, fetch resumes at 4
        vec[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0};
        vec[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0};
        vec[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd1, 1'b0, 32'd0};
        vec[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd2, 1'b1, 32'd0};
        vec[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd3, 1'b1, 32'd0};
        for (int i = 5; i <= 10; i++) vec[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd4, 1'b1, 32'd0};
        vec[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd4, 1'b1, 32'd0};
        vec[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd4, 1'b1, 32'd1};
        vec[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd5, 1'b1, 32'd2};
        vec[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd6, 1'b1, 32'd3};
        vec[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd7, 1'b1, 32'd4};

        do_reset();
        lat = 1;
        for (int i = 0; i < 16; i++) begin
            check("tbl_req_valid", imem_req_valid, vec[i].rv);
            check("tbl_req_addr", imem_req_addr, vec[i].addr);
            check("tbl_dec_valid", dec_valid, vec[i].dv);
            if (vec[i].dv) begin
                check("tbl_dec_pc", dec_pc, vec[i].dpc);
                check("tbl_dec_instr", dec_instr, mem_fn(vec[i].dpc));
            end
            s_en = vec[i].en; s_rdy = vec[i].rdy; s_drdy = vec[i].drdy; s_redir = 1'b0;
            cycle();
        end
        repeat (6) cycle();

        // redirect with three requests in flight and nothing else moving that cycle
        do_reset();
        lat = 4; s_en = 1'b1; s_rdy = 1'b1; s_drdy = 1'b1;
        repeat (4) cycle();
        s_rdy = 1'b0; s_redir = 1'b1; s_rpc = 32'h0000_0100;
        cycle();
        s_rdy = 1'b1; s_redir = 1'b0;
        wait_first_pc("redir_first_pc", 32'h0000_0100);
        check("redir_dropped", m_drop, 32'd3);
`ifdef IFETCH_STATS_EN
        check("stat_discarded_3", stat_discarded, 32'd3);
`endif
        repeat (8) cycle();

        // redirect coinciding with a request accept and a response arrival
        do_reset();
        lat = 2; s_en = 1'b1; s_rdy = 1'b1; s_drdy = 1'b1;
        repeat (3) cycle();
        s_redir = 1'b1; s_rpc = 32'h0000_0200;
        cycle();
        s_redir = 1'b0;
        wait_first_pc("same_cycle_first_pc", 32'h0000_0200);
        repeat (6) cycle();

        // PC wrap from all-ones to zero
        s_redir = 1'b1; s_rpc = 32'hFFFF_FFFF;
        cycle();
        s_redir = 1'b0;
        check("wrap_start_addr", imem_req_addr, 32'hFFFF_FFFF);
        begin
            bit fired = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (imem_req_valid) begin
                    fired = 1'b1;
                    cycle();
                    break;
                end
                cycle();
            end
            if (fired) check("wrap_next_addr", imem_req_addr, 32'h0000_0000);
            else begin
                tests++; fails++;
                $display("FAIL wrap_next_addr: request never issued within 20 cycles");
            end
        end
        wait_first_pc("wrap_first_pc", 32'hFFFF_FFFF);
        repeat (6) cycle();

        // reset while the queue holds two entries
        lat = 1; s_drdy = 1'b0;
        for (int i = 0; i < 20 && m_fifo.size() != 2; i++) cycle();
        check("pre_reset_fill", m_fifo.size(), 32'd2);
        check("pre_reset_dec_valid", dec_valid, 1'b1);
        do_reset();
        s_en = 1'b1; s_rdy = 1'b1; s_drdy = 1'b1;
        cycle();
        check("restart_valid", imem_req_valid, 1'b1);
        check("restart_addr", imem_req_addr, RESET_PC);
        wait_first_pc("restart_first_pc", RESET_PC);
        repeat (8) cycle();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            s_en    = ($urandom_range(0, 9) != 0);
            s_rdy   = ($urandom_range(0, 3) != 0);
            s_drdy  = ($urandom_range(0, 3) != 0);
            s_redir = ($urandom_range(0, 39) == 0);
            s_rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(0, 1))) : $urandom;
            if ($urandom_range(0, 49) == 0) lat = $urandom_range(1, 4);
            cycle();
        end
        s_redir = 1'b0;

`ifdef IFETCH_STATS_EN
        check("stat_fetched", stat_fetched, m_pops);
        check("stat_discarded", stat_discarded, m_drop);
        check("stat_stall", stat_stall, m_stall);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
